uart_rx_os: RTL and testbench

//   Serial UART receiver (8N1, optional parity) with 2-flop input synchroniser,
//   3-sample majority vote per bit, start-glitch rejection and error reporting.

---
 rtl/uart_rx_os.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 2-flop synchroniser, 3-sample majority vote and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit between the data and stop bits.
module uart_rx_os #(
    parameter int DIV        = 861,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       full,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    if (DIV < 8 || DIV > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_os: DIV must be 8..65535 and PARITY_ODD 0 or 1");
    end

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] M_LO     = 16'(DIV / 2 - 1);
    localparam logic [15:0] M_MID    = 16'(DIV / 2);
    localparam logic [15:0] M_HI     = 16'(DIV / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        LINE_BREAK
    } state_t;

    state_t      state, state_d;
    logic        s1, s2;
    logic [15:0] baud_cnt, baud_d, baud_inc;
    logic [2:0]  bit_cnt, bit_d;
    logic [7:0]  shift, shift_d, data_d;
    logic [1:0]  samp, samp_d;
    logic        vote, decide, bit_end;
    logic        valid_d, ferr_d, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic        par_bad, par_bad_d, perr_d, perr_q;
`endif

    assign baud_inc = (baud_cnt == DIV_LAST) ? 16'd0 : baud_cnt + 16'd1;
    assign decide   = (baud_cnt == M_HI);
    assign bit_end  = (baud_cnt == DIV_LAST);
    // The two earlier samples are held in samp; the third is the live s2 at decision time.
    assign vote     = (samp[1] & samp[0]) | (samp[1] & s2) | (samp[0] & s2);
    assign busy     = (state != IDLE);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        data_d  = data;
        samp_d  = samp;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad;
        perr_d    = 1'b0;
`endif
        if (baud_cnt == M_LO || baud_cnt == M_MID)
            samp_d = {samp[0], s2};

        unique case (state)
            IDLE: begin
                if (!s2) begin
                    state_d = START;
                    baud_d  = 16'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            START: begin
                baud_d = baud_inc;
                if (decide && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                baud_d = baud_inc;
                if (decide)
                    shift_d = {vote, shift[7:1]};
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                baud_d = baud_inc;
                if (decide)
                    par_bad_d = vote ^ (^shift) ^ 1'(PARITY_ODD);
                if (bit_end)
                    state_d = STOP;
            end
`endif
            STOP: begin
                baud_d = baud_inc;
                // Leave at mid stop bit so a following start edge is never missed.
                if (decide) begin
                    state_d = IDLE;
                    if (!vote) begin
                        ferr_d  = 1'b1;
                        state_d = LINE_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_d = 1'b1;
`endif
                    end else if (full) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shift;
                        valid_d = 1'b1;
                    end
                end
            end
            LINE_BREAK: begin
                if (s2)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            samp      <= 2'b00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            s1        <= rxd;
            s2        <= s1;
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_cnt   <= bit_d;
            shift     <= shift_d;
            samp      <= samp_d;
            data      <= data_d;
            valid     <= valid_d;
            frame_err <= ferr_d;
            overrun   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os at DIV=16; parity cases build when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT = 2 + 9 * DIV + DIV / 2 + 2 + DIV;
`else
    localparam int EXP_LAT = 2 + 9 * DIV + DIV / 2 + 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       full;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun, busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int last_valid_cyc = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_overlap = 0;
    int b_valid, b_ferr, b_perr, b_ovr;
`ifdef UART_RX_PARITY_EN
    logic flip_par = 1'b0;
`endif

    uart_rx_os #(.DIV(DIV), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .full       (full),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (overrun)    n_ovr++;
        if (int'(valid) + int'(frame_err) + int'(parity_err) + int'(overrun) > 1) n_overlap++;
    end

    task automatic snap();
        b_valid = n_valid;
        b_ferr  = n_ferr;
        b_perr  = n_perr;
        b_ovr   = n_ovr;
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Leaves rxd at the stop-bit level after the full stop-bit time.
    task automatic send_raw(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        fall_cyc = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ flip_par;
        repeat (DIV) @(negedge clk);
`endif
        rxd = stop;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        full  = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({data, valid, frame_err, parity_err, overrun, busy} !== 13'h0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b ov=%b busy=%b expected all 0",
                     data, valid, frame_err, parity_err, overrun, busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_int("idle_after_reset_busy", int'(busy), 0);
    endtask

    task automatic test_basic();
        snap();
        send_raw(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        expect_int("basic_valid_count", n_valid - b_valid, 1);
        expect_int("basic_data", int'(data), 'h55);
        expect_int("basic_latency", last_valid_cyc - (fall_cyc + 1), EXP_LAT);
        expect_int("basic_no_ferr", n_ferr - b_ferr, 0);
        expect_int("basic_busy_after", int'(busy), 0);
    endtask

    task automatic test_glitch();
        snap();
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        expect_int("glitch_busy_in_start", int'(busy), 1);
        repeat (10) @(negedge clk);
        expect_int("glitch_busy_dropped", int'(busy), 0);
        repeat (12 * DIV) @(negedge clk);
        expect_int("glitch_no_pulses",
                   (n_valid - b_valid) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    endtask

    task automatic test_break();
        snap();
        send_raw(8'hA3, 1'b0);
        repeat (40 * DIV) @(negedge clk);
        expect_int("break_busy_held", int'(busy), 1);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        expect_int("break_one_ferr", n_ferr - b_ferr, 1);
        expect_int("break_no_valid", n_valid - b_valid, 0);
        expect_int("break_data_kept", int'(data), 'h55);
        snap();
        send_raw(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        expect_int("after_break_valid", n_valid - b_valid, 1);
        expect_int("after_break_data", int'(data), 'h3C);
    endtask

    task automatic test_overrun();
        snap();
        full = 1'b1;
        send_raw(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        full = 1'b0;
        expect_int("overrun_count", n_ovr - b_ovr, 1);
        expect_int("overrun_no_valid", n_valid - b_valid, 0);
        expect_int("overrun_data_kept", int'(data), 'h3C);
    endtask

    task automatic test_reset_mid_frame();
        snap();
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b0;
            repeat (DIV) @(negedge clk);
        end
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        expect_int("midreset_busy", int'(busy), 0);
        expect_int("midreset_data", int'(data), 0);
        rst_n = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        expect_int("midreset_no_pulses",
                   (n_valid - b_valid) + (n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr), 0);
        snap();
        send_raw(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        expect_int("midreset_next_valid", n_valid - b_valid, 1);
        expect_int("midreset_next_data", int'(data), 'h81);
    endtask

    task automatic test_back_to_back();
        snap();
        send_raw(8'h12, 1'b1);
        send_raw(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        expect_int("b2b_valid_count", n_valid - b_valid, 2);
        expect_int("b2b_data", int'(data), 'h34);
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        snap();
        flip_par = 1'b0;
        send_raw(8'h07, 1'b1);
        repeat (4) @(negedge clk);
        expect_int("parity_good_valid", n_valid - b_valid, 1);
        expect_int("parity_good_data", int'(data), 'h07);
        snap();
        flip_par = 1'b1;
        send_raw(8'h07, 1'b1);
        flip_par = 1'b0;
        repeat (4) @(negedge clk);
        expect_int("parity_bad_perr", n_perr - b_perr, 1);
        expect_int("parity_bad_no_valid", n_valid - b_valid, 0);
`else
        expect_int("parity_err_never_pulsed", n_perr, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_parity();
        expect_int("pulses_never_overlap", n_overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
